// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: NREQ producers each feed a private result FIFO, and a
// round-robin scheduler drains one FIFO head per cycle into a registered CDB broadcast.
module cdb_arbiter #(
  parameter int NREQ      = 2,
  parameter int DEPTH     = 2,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy_i,
  input  logic                        rb_i,
  input  logic [NREQ-1:0]             req_valid_i,
  input  logic [NREQ*ROB_IDX_W-1:0]   req_src_i,
  input  logic [NREQ*DATA_W-1:0]      req_val_i,
  output logic [NREQ-1:0]             req_ready_o,
  output logic                        cdb_valid_o,
  output logic [ROB_IDX_W-1:0]        cdb_src_o,
  output logic [DATA_W-1:0]           cdb_val_o,
  output logic [$clog2(NREQ)-1:0]     cdb_gnt_id_o
);

  localparam int GNT_W = $clog2(NREQ);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ROB_IDX_W-1:0] tagMem_q  [NREQ][DEPTH];
  logic [DATA_W-1:0]    dataMem_q [NREQ][DEPTH];

  logic [PTR_W-1:0] wrPtr_q [NREQ];
  logic [PTR_W-1:0] wrPtr_d [NREQ];
  logic [PTR_W-1:0] rdPtr_q [NREQ];
  logic [PTR_W-1:0] rdPtr_d [NREQ];
  logic [CNT_W-1:0] count_q [NREQ];
  logic [CNT_W-1:0] count_d [NREQ];

  logic [GNT_W-1:0]     rrPtr_q, rrPtr_d;
  logic                 cdbValid_q, cdbValid_d;
  logic [ROB_IDX_W-1:0] cdbSrc_q, cdbSrc_d;
  logic [DATA_W-1:0]    cdbVal_q, cdbVal_d;
  logic [GNT_W-1:0]     cdbGnt_q, cdbGnt_d;

  logic [NREQ-1:0]  store;
  logic [NREQ-1:0]  pop;
  logic             found;
  logic [GNT_W-1:0] winner;
  int               scanIdx;

  // Tag 0 means "no dependency": the handshake completes but nothing is buffered.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = rdy_i & ~rst & (count_q[i] < CNT_W'(DEPTH));
      store[i] = req_valid_i[i] & req_ready_o[i] & ~rb_i
                 & (|req_src_i[i*ROB_IDX_W +: ROB_IDX_W]);
    end
  end

  always_comb begin
    found   = 1'b0;
    winner  = '0;
    scanIdx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scanIdx = int'(rrPtr_q) + k;
      if (scanIdx >= NREQ) scanIdx = scanIdx - NREQ;
      if (!found && (count_q[scanIdx] != '0)) begin
        found  = 1'b1;
        winner = GNT_W'(scanIdx);
      end
    end
  end

  always_comb begin
    rrPtr_d    = rrPtr_q;
    cdbValid_d = 1'b0;
    cdbSrc_d   = cdbSrc_q;
    cdbVal_d   = cdbVal_q;
    cdbGnt_d   = cdbGnt_q;
    for (int i = 0; i < NREQ; i++) begin
      pop[i]     = 1'b0;
      wrPtr_d[i] = wrPtr_q[i];
      rdPtr_d[i] = rdPtr_q[i];
      count_d[i] = count_q[i];
    end

    if (rb_i) begin
      rrPtr_d = '0;
      for (int i = 0; i < NREQ; i++) begin
        wrPtr_d[i] = '0;
        rdPtr_d[i] = '0;
        count_d[i] = '0;
      end
    end else if (rdy_i) begin
      if (found) begin
        cdbValid_d = 1'b1;
        cdbSrc_d   = tagMem_q[winner][rdPtr_q[winner]];
        cdbVal_d   = dataMem_q[winner][rdPtr_q[winner]];
        cdbGnt_d   = winner;
        rrPtr_d    = (winner == GNT_W'(NREQ - 1)) ? '0 : winner + 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
        pop[i]     = found && (winner == GNT_W'(i));
        wrPtr_d[i] = wrPtr_q[i] + PTR_W'(store[i]);
        rdPtr_d[i] = rdPtr_q[i] + PTR_W'(pop[i]);
        count_d[i] = count_q[i] + CNT_W'(store[i]) - CNT_W'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (store[i]) begin
        tagMem_q[i][wrPtr_q[i]]  <= req_src_i[i*ROB_IDX_W +: ROB_IDX_W];
        dataMem_q[i][wrPtr_q[i]] <= req_val_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q    <= '0;
      cdbValid_q <= 1'b0;
      cdbSrc_q   <= '0;
      cdbVal_q   <= '0;
      cdbGnt_q   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        wrPtr_q[i] <= '0;
        rdPtr_q[i] <= '0;
        count_q[i] <= '0;
      end
    end else begin
      rrPtr_q    <= rrPtr_d;
      cdbValid_q <= cdbValid_d;
      cdbSrc_q   <= cdbSrc_d;
      cdbVal_q   <= cdbVal_d;
      cdbGnt_q   <= cdbGnt_d;
      for (int i = 0; i < NREQ; i++) begin
        wrPtr_q[i] <= wrPtr_d[i];
        rdPtr_q[i] <= rdPtr_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  assign cdb_valid_o  = cdbValid_q;
  assign cdb_src_o    = cdbSrc_q;
  assign cdb_val_o    = cdbVal_q;
  assign cdb_gnt_id_o = cdbGnt_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares a single common data bus (CDB) broadcast slot among NREQ result producers (ALU, load unit, …).
- Each producer pushes {rob_idx, value} into a private DEPTH-entry FIFO inside the block.
- A round-robin scheduler pops one FIFO head per cycle into a registered CDB output, which feeds the dispatcher, RS, LSB and ROB wakeup logic.
- Rollback flushes every buffered result.

Parameters:
- NREQ, 2, number of producers (≥2).
- DEPTH, 2, entries per producer FIFO (power of two, ≥2).
- ROB_IDX_W, 4, ROB tag width. Tag 0 is the reserved "no dependency" tag.
- DATA_W, 32, result width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low = freeze
- rb  in  1  rollback/flush pulse
- req_valid  in  NREQ  producer i has a result
- req_src  in  NREQ*ROB_IDX_W  producer i ROB tag; slice i = bits [i*ROB_IDX_W +: ROB_IDX_W]
- req_val  in  NREQ*DATA_W  producer i result; slice i likewise
- req_ready  out  NREQ  FIFO i can accept this cycle
- cdb_valid  out  1  broadcast valid
- cdb_src  out  ROB_IDX_W  broadcast tag
- cdb_val  out  DATA_W  broadcast value
- cdb_gnt_id  out  clog2(NREQ)  producer index of the current broadcast

Behaviour:
- Reset (rst high at a posedge):
  - All FIFOs empty; rr_ptr=0.
  - cdb_valid=0, cdb_src=0, cdb_val=0, cdb_gnt_id=0.
  - req_ready=0 during the reset cycle.
  - rst has priority over rb and rdy; reset mid-stream discards all buffered data.
- Readiness:
  - req_ready[i] = rdy & !rst & (count_i < DEPTH), computed from the registered count.
  - A full FIFO is not ready even if it pops that same cycle.
- Push: on a posedge with req_valid[i] & req_ready[i] & !rb, the entry is written at wr_ptr_i; wr_ptr_i and count_i advance.
- Tag-0 drop: an entry with req_src[i]==0 is accepted (handshake completes) but not stored; it is never broadcast.
- Arbitration (each cycle, rdy high, rb low):
  - Candidates = FIFOs with count>0 at cycle start.
  - Winner = first candidate scanning i = rr_ptr, rr_ptr+1, …, mod NREQ.
  - On the posedge: winner head is popped; cdb_valid<=1, cdb_src<=head tag, cdb_val<=head value, cdb_gnt_id<=winner; rr_ptr<=(winner+1) mod NREQ.
  - With no candidate: cdb_valid<=0 and rr_ptr is unchanged. cdb_src, cdb_val and cdb_gnt_id hold their previous values.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance (mod DEPTH).
- Latency:
  - A result accepted at edge E is broadcast earliest in the cycle following edge E+1, i.e. cdb_valid is high from E+1 to E+2.
  - No combinational bypass.
  - Throughput is one broadcast per cycle across all producers.
- Fairness: with all FIFOs continuously non-empty, grants rotate 0,1,…,NREQ-1,0,… Each producer waits at most NREQ-1 cycles.
- Rollback (rb high, rst low, at a posedge):
  - All FIFO pointers and counts cleared; pushes that cycle are discarded.
  - cdb_valid<=0; rr_ptr<=0.
  - The next cycle accepts normally.
- rdy low:
  - No push, no pop; FIFO contents and rr_ptr hold.
  - cdb_valid<=0, so a result is never broadcast twice.
- Widths: all pointer arithmetic is modulo DEPTH/NREQ; no overflow is possible because push is gated by count<DEPTH.

Test Plan:
- Single result: req_valid=01, src0=5, val0=0x1234 at edge E → cdb_valid=1, src=5, val=0x1234, gnt_id=0 for exactly one cycle after E+1; cdb_valid=0 afterwards.
- Contention: both producers push every cycle (src0=1,2,3…; src1=9,10,11…) → gnt_id alternates 0,1,0,1; tag order within each producer is preserved; req_ready toggles so that no entry is lost.
- Full FIFO: producer 1 pushes 3 results back-to-back while producer 0 keeps FIFO0 non-empty → req_ready[1]=0 once count=2; the third value is accepted only after a pop; all 3 tags reach the CDB in order.
- Rollback: 2 entries buffered per FIFO, then rb=1 with simultaneous pushes → cdb_valid=0 the next cycle; none of the 4 old or 2 new tags is ever broadcast; rr_ptr=0, so the next grant goes to producer 0.
- rdy freeze: entries buffered, then rdy=0 for 3 cycles → cdb_valid=0 and req_ready=0 throughout; after rdy=1 broadcasting resumes with the same head and the same rr_ptr order.
- Tag 0 / reset: a push with src=0 completes the handshake but produces no CDB pulse; rst asserted while FIFOs hold data → all outputs are 0 the next cycle and no stale tag appears afterwards.
